// File: rtl/vu_io_shadow.sv
// vu_io_shadow: write-only shadow of the Vector-06c system PPI (KR580VV55).
// Tracks the control word and ports A/B/C (including BSR bit set/reset)
// from VU I/O writes on the expansion bus. It also runs NCH saturating
// counters that count falling edges of selected port C bits.
module vu_io_shadow #(
  parameter logic [7:0]       BASE   = 8'h00,
  parameter int               NCH    = 2,
  parameter int               CNT_W  = 4,
  parameter int               THRESH = 4,
  parameter logic [3*NCH-1:0] WATCH  = {3'd0, 3'd3}
) (
  input  logic                 clk_cpu,
  input  logic                 sys_reset,
  input  logic [7:0]           shavv,
  input  logic [7:0]           data,
  input  logic                 negedge_zpvv_n,
  input  logic [NCH-1:0]       cnt_en,
  input  logic [NCH-1:0]       cnt_clr,
  output logic [7:0]           port_cw,
  output logic [7:0]           port_a,
  output logic [7:0]           port_b,
  output logic [7:0]           port_c,
  output logic [3:0]           wr_strobe,
  output logic [NCH*CNT_W-1:0] cnt,
  output logic [NCH-1:0]       cnt_hit,
  output logic [NCH-1:0]       hit_pulse
);

  localparam logic [CNT_W-1:0] THR = CNT_W'(THRESH);

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) return v;
    else                    return v + 1'b1;
  endfunction

  logic                 w_wr;
  logic [1:0]           w_off;
  logic [7:0]           w_cw_nxt;
  logic [7:0]           w_a_nxt;
  logic [7:0]           w_b_nxt;
  logic [7:0]           w_c_nxt;
  logic [NCH-1:0]       w_fall;
  logic [CNT_W-1:0]     w_cnt_nxt [NCH];
  logic [NCH-1:0]       w_pulse_nxt;

  logic [7:0]           r_port_cw;
  logic [7:0]           r_port_a;
  logic [7:0]           r_port_b;
  logic [7:0]           r_port_c;
  logic [3:0]           r_wr_strobe;
  logic [CNT_W-1:0]     r_cnt [NCH];
  logic [NCH-1:0]       r_hit_pulse;

  assign w_wr  = negedge_zpvv_n & (shavv[7:2] == BASE[7:2]);
  assign w_off = shavv[1:0];

  // Next value of every shadow register for the current bus write.
  always_comb begin
    w_cw_nxt = r_port_cw;
    w_a_nxt  = r_port_a;
    w_b_nxt  = r_port_b;
    w_c_nxt  = r_port_c;
    if (w_wr) begin
      case (w_off)
        2'd0: begin
          if (data[7]) begin
            // Mode set also resets the PPI output latches.
            w_cw_nxt = data;
            w_a_nxt  = 8'h00;
            w_b_nxt  = 8'h00;
            w_c_nxt  = 8'h00;
          end else begin
            w_c_nxt[data[3:1]] = data[0];
          end
        end
        2'd1:    w_c_nxt = data;
        2'd2:    w_b_nxt = data;
        default: w_a_nxt = data;
      endcase
    end
  end

  // Falling-edge detect on watched port C bits and counter next-state.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_fall[i]      = r_port_c[WATCH[3*i +: 3]] & ~w_c_nxt[WATCH[3*i +: 3]];
      w_cnt_nxt[i]   = r_cnt[i];
      w_pulse_nxt[i] = 1'b0;
      if (cnt_clr[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (w_fall[i] && cnt_en[i]) begin
        w_cnt_nxt[i] = sat_inc(r_cnt[i]);
        // Only a real step onto THRESH pulses; a saturated hold does not.
        w_pulse_nxt[i] = (r_cnt[i] != {CNT_W{1'b1}}) && (w_cnt_nxt[i] == THR);
      end
    end
  end

  // Shadow registers and write strobes.
  always_ff @(posedge clk_cpu or posedge sys_reset) begin
    if (sys_reset) begin
      r_port_cw   <= 8'h00;
      r_port_a    <= 8'h00;
      r_port_b    <= 8'h00;
      r_port_c    <= 8'h00;
      r_wr_strobe <= 4'b0000;
    end else begin
      r_port_cw   <= w_cw_nxt;
      r_port_a    <= w_a_nxt;
      r_port_b    <= w_b_nxt;
      r_port_c    <= w_c_nxt;
      r_wr_strobe <= w_wr ? (4'b0001 << w_off) : 4'b0000;
    end
  end

  // Edge counters and registered threshold pulses.
  always_ff @(posedge clk_cpu or posedge sys_reset) begin
    if (sys_reset) begin
      for (int i = 0; i < NCH; i++) r_cnt[i] <= '0;
      r_hit_pulse <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) r_cnt[i] <= w_cnt_nxt[i];
      r_hit_pulse <= w_pulse_nxt;
    end
  end

  assign port_cw   = r_port_cw;
  assign port_a    = r_port_a;
  assign port_b    = r_port_b;
  assign port_c    = r_port_c;
  assign wr_strobe = r_wr_strobe;
  assign hit_pulse = r_hit_pulse;

  for (genvar g = 0; g < NCH; g++) begin : g_out
    assign cnt[CNT_W*g +: CNT_W] = r_cnt[g];
    assign cnt_hit[g]            = (r_cnt[g] >= THR);
  end

endmodule

// File: tb/tb_vu_io_shadow.sv
// Directed testbench for vu_io_shadow: default instance, a narrow
// saturating-counter instance and an instance at BASE=8'h04, all on one bus.
module tb_vu_io_shadow;

  logic       clk_cpu = 1'b0;
  logic       sys_reset = 1'b1;
  logic [7:0] shavv = 8'h00;
  logic [7:0] data = 8'h00;
  logic       negedge_zpvv_n = 1'b0;
  logic [1:0] cnt_en = 2'b11;
  logic [1:0] cnt_clr = 2'b00;

  logic [7:0] d_cw, d_a, d_b, d_c;
  logic [3:0] d_ws;
  logic [7:0] d_cnt;
  logic [1:0] d_hit, d_hp;

  logic [7:0] s_cw, s_a, s_b, s_c;
  logic [3:0] s_ws;
  logic [3:0] s_cnt;
  logic [1:0] s_hit, s_hp;

  logic [7:0] e_cw, e_a, e_b, e_c;
  logic [3:0] e_ws;
  logic [7:0] e_cnt;
  logic [1:0] e_hit, e_hp;

  int n_pass = 0;
  int n_total = 0;
  int d_pulses = 0;
  int s_pulses = 0;

  always #5 clk_cpu = ~clk_cpu;

  vu_io_shadow u_d (
    .clk_cpu(clk_cpu), .sys_reset(sys_reset), .shavv(shavv), .data(data),
    .negedge_zpvv_n(negedge_zpvv_n), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
    .port_cw(d_cw), .port_a(d_a), .port_b(d_b), .port_c(d_c),
    .wr_strobe(d_ws), .cnt(d_cnt), .cnt_hit(d_hit), .hit_pulse(d_hp));

  vu_io_shadow #(.CNT_W(2), .THRESH(3)) u_s (
    .clk_cpu(clk_cpu), .sys_reset(sys_reset), .shavv(shavv), .data(data),
    .negedge_zpvv_n(negedge_zpvv_n), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
    .port_cw(s_cw), .port_a(s_a), .port_b(s_b), .port_c(s_c),
    .wr_strobe(s_ws), .cnt(s_cnt), .cnt_hit(s_hit), .hit_pulse(s_hp));

  vu_io_shadow #(.BASE(8'h04)) u_e (
    .clk_cpu(clk_cpu), .sys_reset(sys_reset), .shavv(shavv), .data(data),
    .negedge_zpvv_n(negedge_zpvv_n), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
    .port_cw(e_cw), .port_a(e_a), .port_b(e_b), .port_c(e_c),
    .wr_strobe(e_ws), .cnt(e_cnt), .cnt_hit(e_hit), .hit_pulse(e_hp));

  // Count ch0 threshold pulses, sampled mid-cycle.
  always @(negedge clk_cpu) begin
    if (!sys_reset && d_hp[0]) d_pulses++;
    if (!sys_reset && s_hp[0]) s_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One bus write: strobe high for one cycle; returns at the negedge
  // following the capturing posedge, where the result is visible.
  task automatic wr(input logic [7:0] addr, input logic [7:0] d);
    @(negedge clk_cpu);
    shavv = addr;
    data = d;
    negedge_zpvv_n = 1'b1;
    @(negedge clk_cpu);
    negedge_zpvv_n = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_cpu);
    sys_reset = 1'b1;
    @(negedge clk_cpu);
    sys_reset = 1'b0;
  endtask

  initial begin
    // Reset values
    @(negedge clk_cpu);
    chk("rst_cw", d_cw, 8'h00);
    chk("rst_ports", {d_a, d_b, d_c}, 24'h0);
    chk("rst_cnt", d_cnt, 8'h00);
    chk("rst_misc", {d_ws, d_hit, d_hp}, 8'h00);
    sys_reset = 1'b0;

    // Direct write to port A
    wr(8'h03, 8'hA5);
    chk("a_val", d_a, 8'hA5);
    chk("a_strobe", d_ws, 4'b1000);
    chk("a_others", {d_cw, d_b, d_c}, 24'h0);
    @(negedge clk_cpu);
    chk("a_strobe_end", d_ws, 4'b0000);

    // BSR set / reset of bit 3
    wr(8'h00, 8'h07);
    chk("bsr_set", d_c, 8'h08);
    chk("bsr_strobe", d_ws, 4'b0001);
    wr(8'h00, 8'h06);
    chk("bsr_clr", d_c, 8'h00);
    chk("bsr_cnt", d_cnt, 8'h01);
    chk("bsr_cw", d_cw, 8'h00);
    chk("sat_cnt1", s_cnt, 4'h1);

    // Toggles 2 and 3
    wr(8'h00, 8'h07); wr(8'h00, 8'h06);
    wr(8'h00, 8'h07); wr(8'h00, 8'h06);
    chk("cnt3", d_cnt, 8'h03);
    chk("hit_before", d_hit, 2'b00);
    chk("sat_at3", s_cnt, 4'h3);
    chk("sat_hit", s_hit, 2'b01);
    // Toggle 4 reaches THRESH
    wr(8'h00, 8'h07); wr(8'h00, 8'h06);
    chk("cnt4", d_cnt, 8'h04);
    chk("hit4", d_hit, 2'b01);
    chk("pulse4", d_hp, 2'b01);
    @(negedge clk_cpu);
    chk("pulse4_end", d_hp, 2'b00);
    // Toggle 5 goes past THRESH without a pulse
    wr(8'h00, 8'h07); wr(8'h00, 8'h06);
    chk("cnt5", d_cnt, 8'h05);
    chk("pulse5", d_hp, 2'b00);
    chk("d_pulses", d_pulses, 1);
    chk("sat_cnt5", s_cnt, 4'h3);
    chk("sat_pulses", s_pulses, 1);

    // Mode set clears A/B/C and counts falls on both channels
    do_reset();
    chk("rst2_cnt", d_cnt, 8'h00);
    wr(8'h02, 8'h5A);
    chk("b_val", d_b, 8'h5A);
    wr(8'h03, 8'hC3);
    wr(8'h01, 8'h09);
    chk("c_val", d_c, 8'h09);
    chk("c_nocount", d_cnt, 8'h00);
    wr(8'h00, 8'h82);
    chk("ms_cw", d_cw, 8'h82);
    chk("ms_ports", {d_a, d_b, d_c}, 24'h0);
    chk("ms_cnt", d_cnt, 8'h11);
    chk("ms_strobe", d_ws, 4'b0001);

    // Clear beats a same-cycle edge; disabled channel holds
    wr(8'h01, 8'h09);
    cnt_clr = 2'b01;
    cnt_en = 2'b01;
    wr(8'h01, 8'h00);
    chk("clr_cnt", d_cnt, 8'h10);
    chk("clr_pulse", d_hp, 2'b00);
    chk("clr_portc", d_c, 8'h00);
    cnt_clr = 2'b00;
    cnt_en = 2'b11;

    // BASE=8'h04 decode window
    do_reset();
    wr(8'h01, 8'hFF);
    chk("e_out_c", e_c, 8'h00);
    chk("e_out_ws", e_ws, 4'b0000);
    wr(8'h05, 8'h3C);
    chk("e_in_c", e_c, 8'h3C);
    chk("e_in_ws", e_ws, 4'b0010);
    chk("d_ignores_05", d_c, 8'hFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vu_io_shadow.md
# vu_io_shadow

Parametrised shadow of the Vector-06c system PPI (КР580ВВ55), watching ВУ I/O writes on the expansion bus. It keeps write-only copies of the control word and ports A, B and C, including BSR bit-set/reset writes. It also runs NCH independent falling-edge counters on selected port C bits. It generalises the single-bit RUS/LAT spy and blink counter in the top level so the fakerom controller, keyboard-LED signalling and future boot handshakes can share one block.

## Interface
Parameters:
- BASE, 8'h00: PPI base port. BASE[1:0] must be 2'b00; the block decodes BASE..BASE+3.
- NCH, 2: number of edge-counter channels, 1..8.
- CNT_W, 4: counter width per channel, 2..8.
- THRESH, 4: hit threshold, 1..2^CNT_W-1.
- WATCH, {3'd0,3'd3}: 3*NCH bits. Field i (bits 3i+2:3i) is the port C bit watched by channel i. The default gives ch0 = bit 3 (RUS/LAT) and ch1 = bit 0.

Ports:
- clk_cpu  in  1  system clock, 24 MHz
- sys_reset  in  1  asynchronous, active-high reset
- shavv  in  8  clean ШАВВ port address from bus_sampler
- data  in  8  ВУ ШД data bus
- negedge_zpvv_n  in  1  one-cycle ЗПВВ falling-edge strobe from bus_sampler
- cnt_en  in  NCH  per-channel count enable (level)
- cnt_clr  in  NCH  per-channel synchronous clear (level)
- port_cw  out  8  last mode-set control word
- port_a  out  8  port A shadow (offset 3)
- port_b  out  8  port B shadow (offset 2)
- port_c  out  8  port C shadow (offset 1)
- wr_strobe  out  4  one-cycle pulse per offset, bit k = offset k
- cnt  out  NCH*CNT_W  counters packed; channel i at [CNT_W*i +: CNT_W]
- cnt_hit  out  NCH  level, cnt_i >= THRESH
- hit_pulse  out  NCH  one-cycle pulse when cnt_i becomes THRESH by increment

## Operation
- Write decode: `wr = negedge_zpvv_n & (shavv[7:2] == BASE[7:2])`, with `off = shavv[1:0]`. Port mapping follows the Vector-06c layout: 0 = CW, 1 = C, 2 = B, 3 = A.
- off 0, data[7]=1 (mode set):
  - port_cw <= data.
  - port_a, port_b and port_c are cleared to 8'h00, matching the PPI's output-latch reset.
- off 0, data[7]=0 (BSR):
  - port_c[data[3:1]] <= data[0].
  - port_cw is unchanged.
- off 1/2/3: the addressed shadow register <= data.
- wr_strobe[off] pulses on every decoded write, including BSR writes.
- Edge detection compares the current and next port_c value on the cycle of the update.
  - A watched bit going 1->0 through any write path (direct, BSR or mode-set clear) is a falling edge for that channel.
  - 0->0, 1->1 and 0->1 never count.
- Channel i, in priority order:
  1. cnt_clr[i] forces cnt_i to 0.
  2. Otherwise, a falling edge with cnt_en[i]=1 increments cnt_i, saturating at all-ones.
  3. Otherwise cnt_i holds.
- cnt_hit is combinational from the cnt registers.
- hit_pulse[i] is registered and asserts only on an increment where the next value == THRESH. Saturation does not produce a pulse, and neither does holding at THRESH or above.
- Writes outside BASE..BASE+3 and all reads have no effect.

## Timing
- Reset: all outputs are 0. port_cw, port_a, port_b, port_c = 8'h00; cnt = 0; cnt_hit = 0; hit_pulse = 0; wr_strobe = 0.
- Latency: if negedge_zpvv_n is high in cycle N, the shadow registers, wr_strobe, cnt and hit_pulse are all visible in cycle N+1.
- cnt_hit follows cnt in the same cycle.
- wr_strobe and hit_pulse last exactly one cycle. Back-to-back strobes give back-to-back pulses.
- Only one write can occur per cycle, because the strobe is one cycle wide.
- Clear and edge in the same cycle: clear wins, cnt = 0, no hit_pulse.
- cnt_en low: port registers still update, but the counter holds.
- Channels watching the same bit count identically when they have identical en/clr.
- sys_reset asserted mid-operation clears everything asynchronously. No edge is counted from the reset-induced change of port_c.

## Test plan
- Reset values: after sys_reset, all outputs are 0. Then write shavv=8'h03, data=8'hA5 -> port_a=8'hA5, wr_strobe=4'b1000 for 1 cycle; other shadow registers stay 0.
- BSR, BASE=0, cnt_en=2'b11:
  - CW 8'h07 -> port_c=8'h08.
  - CW 8'h06 -> port_c=8'h00, cnt ch0=1.
  - port_cw stays 8'h00 throughout.
- Ch0 reaching THRESH=4, using four 1->0 toggles of bit 3 (via BSR):
  - After the 4th toggle: cnt ch0=4, cnt_hit[0]=1, hit_pulse[0] high for exactly one cycle.
  - A 5th toggle gives cnt=5 and no pulse.
- Saturation (CNT_W=2, THRESH=3): five falling edges -> cnt stays 3, exactly one hit_pulse.
- Mode-set clear:
  - Write C=8'h09, then CW=8'h82 -> port_cw=8'h82, ports A/B/C=0.
  - ch0 and ch1 each count 1.
- Clear priority: cnt_clr[0]=1 in the same cycle as a falling edge -> cnt ch0=0, no pulse. With cnt_en[1]=0, ch1 holds.
- BASE=8'h04: a write to port 8'h01 has no effect and no wr_strobe.
